// File: rtl/demux_dist.sv
// Demultiplexer distributing one input word per cycle into N_OUT one-entry lane buffers.
// Words addressed past the last lane are discarded and counted.
module demux_dist #(
  parameter int unsigned N_OUT = 31,
  parameter int unsigned WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               sel,
  input  logic [WIDTH-1:0]         inp,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [N_OUT*WIDTH-1:0]   out_data,
  output logic [N_OUT-1:0]         out_valid,
  input  logic [N_OUT-1:0]         out_ack,
  output logic                     drop_err,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                   sel_ok;
  logic [N_OUT-1:0]       hit;
  logic [N_OUT-1:0]       load;
  logic [N_OUT-1:0]       valid_nxt;
  logic [N_OUT*WIDTH-1:0] data_nxt;
  logic                   xfer;
  logic                   drop;

  // Lane decode and acceptance; a lane being acked this cycle can take a new word.
  always_comb begin
    sel_ok    = (32'(sel) < N_OUT);
    hit       = '0;
    load      = '0;
    valid_nxt = '0;
    data_nxt  = out_data;
    for (int i = 0; i < int'(N_OUT); i++) begin
      hit[i] = sel_ok && (32'(sel) == 32'(i));
    end
    in_ready = !sel_ok || (|(hit & (~out_valid | out_ack)));
    xfer     = in_valid && in_ready;
    drop     = xfer && !sel_ok;
    for (int i = 0; i < int'(N_OUT); i++) begin
      load[i]      = xfer && hit[i];
      valid_nxt[i] = load[i] || (out_valid[i] && !out_ack[i]);
      if (load[i]) begin
        data_nxt[i*WIDTH +: WIDTH] = inp;
      end
    end
  end

  // Lane registers; empty lanes keep their last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      out_data  <= '0;
      drop_err  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      drop_err  <= drop;
      if (drop && (drop_cnt != CNT_MAX)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_dist.sv
// Self-checking bench for demux_dist: directed table, corner-case sequences and
// randomized traffic against a lane-array reference model.
module tb_demux_dist;

  localparam int NL = 31;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    sel = '0;
  logic [1:0]    inp = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [61:0]   out_data;
  logic [30:0]   out_valid;
  logic [30:0]   out_ack = '0;
  logic          drop_err;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad = 0;

  bit       mv [NL];
  bit [1:0] md [NL];
  int       mcnt;
  bit       merr;
  bit       rdy_seen;

  demux_dist dut (
    .clk(clk), .reset(reset), .sel(sel), .inp(inp), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .drop_err(drop_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [30:0] pack_valid();
    logic [30:0] r;
    for (int i = 0; i < NL; i++) r[i] = mv[i];
    return r;
  endfunction

  function automatic logic [61:0] pack_data();
    logic [61:0] r;
    for (int i = 0; i < NL; i++) r[i*2 +: 2] = md[i];
    return r;
  endfunction

  function automatic bit model_ready(input logic [4:0] s, input logic [30:0] a);
    if (int'(s) >= NL) return 1'b1;
    return !mv[s] || a[s];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) begin
      mv[i] = 1'b0;
      md[i] = 2'b00;
    end
    mcnt = 0;
    merr = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(pack_valid()));
    chk({tag, ".out_data"},  64'(out_data),  64'(pack_data()));
    chk({tag, ".drop_err"},  64'(drop_err),  64'(merr));
    chk({tag, ".drop_cnt"},  64'(drop_cnt),  64'(mcnt));
  endtask

  // One clock cycle: drive, check readiness, advance model and compare after the edge.
  task automatic step(input logic [4:0] s, input logic [1:0] d, input logic v,
                      input logic [30:0] a, input string tag);
    bit r;
    sel = s; inp = d; in_valid = v; out_ack = a;
    #2;
    r = model_ready(s, a);
    rdy_seen = in_ready;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(r));
    merr = 1'b0;
    if (v && r) begin
      if (int'(s) < NL) begin
        mv[s] = 1'b1;
        md[s] = d;
      end else begin
        merr = 1'b1;
        if (mcnt < 255) mcnt++;
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (!(v && r && int'(s) == i) && a[i]) mv[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_state(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ack = '0; sel = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic [4:0]  s;
    logic [1:0]  d;
    logic        v;
    logic [30:0] a;
    logic        rdy;
    int          lane;
    logic        lv;
    logic [1:0]  ld;
    logic        err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [61:0] exp_d;
    logic [30:0] a12;
    logic [30:0] aall;
    a12  = 31'(1) << 12;
    aall = '1;
    // sel, inp, valid, ack, ready, lane, lane valid, lane data, drop_err, drop_cnt
    tbl[0]  = '{5'd0,  2'd0, 1'b0, aall,  1'b1, 0,  1'b0, 2'd0, 1'b0, 8'd0};
    tbl[1]  = '{5'd30, 2'd3, 1'b1, '0,    1'b1, 30, 1'b1, 2'd3, 1'b0, 8'd0};
    tbl[2]  = '{5'd12, 2'd1, 1'b1, '0,    1'b1, 12, 1'b1, 2'd1, 1'b0, 8'd0};
    tbl[3]  = '{5'd12, 2'd2, 1'b1, '0,    1'b0, 12, 1'b1, 2'd1, 1'b0, 8'd0};
    tbl[4]  = '{5'd12, 2'd2, 1'b1, a12,   1'b1, 12, 1'b1, 2'd2, 1'b0, 8'd0};
    tbl[5]  = '{5'd0,  2'd0, 1'b0, a12,   1'b1, 12, 1'b0, 2'd2, 1'b0, 8'd0};
    tbl[6]  = '{5'd12, 2'd3, 1'b1, '0,    1'b1, 12, 1'b1, 2'd3, 1'b0, 8'd0};
    tbl[7]  = '{5'd13, 2'd0, 1'b1, '0,    1'b1, 13, 1'b1, 2'd0, 1'b0, 8'd0};
    tbl[8]  = '{5'd12, 2'd0, 1'b0, '0,    1'b0, 12, 1'b1, 2'd3, 1'b0, 8'd0};
    tbl[9]  = '{5'd31, 2'd2, 1'b1, '0,    1'b1, 30, 1'b1, 2'd3, 1'b1, 8'd1};
    tbl[10] = '{5'd0,  2'd0, 1'b0, '0,    1'b1, 30, 1'b1, 2'd3, 1'b0, 8'd1};
    tbl[11] = '{5'd31, 2'd0, 1'b0, aall,  1'b1, 30, 1'b0, 2'd3, 1'b0, 8'd1};

    // Reset state, then the first transfer lands on the first edge after release.
    model_clear();
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'(0));
    chk("rst.out_data", 64'(out_data), 64'(0));
    chk("rst.in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst.drop_cnt", 64'(drop_cnt), 64'(0));
    chk("rst.drop_err", 64'(drop_err), 64'(0));

    foreach (tbl[k]) begin
      step(tbl[k].s, tbl[k].d, tbl[k].v, tbl[k].a, $sformatf("tbl%0d", k));
      chk($sformatf("tbl%0d.ready", k), 64'(rdy_seen), 64'(tbl[k].rdy));
      chk($sformatf("tbl%0d.lane_valid", k), 64'(out_valid[tbl[k].lane]), 64'(tbl[k].lv));
      chk($sformatf("tbl%0d.lane_data", k), 64'(out_data[tbl[k].lane*2 +: 2]), 64'(tbl[k].ld));
      chk($sformatf("tbl%0d.err", k), 64'(drop_err), 64'(tbl[k].err));
      chk($sformatf("tbl%0d.cnt", k), 64'(drop_cnt), 64'(tbl[k].cnt));
    end
    chk("iso.lane12", 64'(out_data[24 +: 2]), 64'(2'b11));
    chk("iso.lane13", 64'(out_data[26 +: 2]), 64'(2'b00));

    // Sweep all lanes, no acks.
    do_reset();
    for (int s = 0; s < NL; s++) step(5'(s), 2'(s % 4), 1'b1, '0, "sweep");
    for (int i = 0; i < NL; i++) exp_d[i*2 +: 2] = 2'(i % 4);
    chk("sweep.valid", 64'(out_valid), 64'(31'h7fff_ffff));
    chk("sweep.data", 64'(out_data), 64'(exp_d));
    chk("sweep.cnt", 64'(drop_cnt), 64'(0));

    // Invalid lane drops, then saturation.
    for (int k = 0; k < 3; k++) begin
      step(5'd31, 2'(k), 1'b1, '0, "drop");
      chk("drop.pulse", 64'(drop_err), 64'(1));
    end
    chk("drop.cnt3", 64'(drop_cnt), 64'(3));
    chk("drop.valid", 64'(out_valid), 64'(31'h7fff_ffff));
    step(5'd31, 2'd0, 1'b0, '0, "drop_idle");
    chk("drop.err_low", 64'(drop_err), 64'(0));
    for (int k = 0; k < 300; k++) step(5'd31, 2'd1, 1'b1, '0, "sat");
    chk("sat.cnt", 64'(drop_cnt), 64'(255));

    // Asynchronous reset mid-operation.
    do_reset();
    step(5'd0, 2'd1, 1'b1, '0, "mid");
    step(5'd29, 2'd2, 1'b1, '0, "mid");
    step(5'd30, 2'd3, 1'b1, '0, "mid");
    step(5'd31, 2'd3, 1'b1, '0, "mid");
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst.valid", 64'(out_valid), 64'(0));
    chk("arst.data", 64'(out_data), 64'(0));
    chk("arst.cnt", 64'(drop_cnt), 64'(0));
    chk("arst.err", 64'(drop_err), 64'(0));
    chk("arst.ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    step(5'd0, 2'd0, 1'b0, '0, "post_rst");
    chk("post_rst.valid", 64'(out_valid), 64'(0));

    // Randomized traffic with sparse acks.
    for (int k = 0; k < 3000; k++) begin
      logic [4:0]  rs;
      logic [30:0] ra;
      rs = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      ra = '0;
      for (int i = 0; i < NL; i++) ra[i] = ($urandom_range(0, 3) == 0);
      step(rs, 2'($urandom), 1'($urandom_range(0, 3) != 0), ra, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
